ahb_dmem_master: RTL and testbench

Data-memory AHB-Lite master sitting directly downstream of the store unit (and alongside the load unit) in the RISC-V core. It accepts one load or store request at a time and converts the store unit's word address, lane-aligned data and byte mask into a single non-burst AHB transfer. The transfer has a registered address phase and data phase, and the block honours HREADY wait states and the two-cycle ERROR response. It returns raw read data or an error pulse to the core and tells upstream when it can take a new request.

---
 rtl/ahb_dmem_pkg.sv | 17 +
 rtl/ahb_size_decode.sv | 41 ++++
 rtl/ahb_dmem_master.sv | 114 +++++++++++
 tb/tb_ahb_dmem_master.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_dmem_pkg.sv
// Shared AHB-Lite encodings and FSM state type for the data-memory master.
package ahb_dmem_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA
    } state_t;

endpackage

// File: rtl/ahb_size_decode.sv
// Maps a store byte mask, or a load size plus byte offset, to HSIZE, the
// low address bits and a legality flag.
module ahb_size_decode
    import ahb_dmem_pkg::*;
(
    input  logic       is_write,
    input  logic [3:0] mask,
    input  logic [1:0] rd_size,
    input  logic [1:0] rd_offset,
    output logic [2:0] hsize,
    output logic [1:0] offset,
    output logic       legal
);

    always_comb begin
        hsize  = HSIZE_BYTE;
        offset = 2'b00;
        legal  = 1'b0;
        if (is_write) begin
            case (mask)
                4'b0001: begin offset = 2'd0; legal = 1'b1; end
                4'b0010: begin offset = 2'd1; legal = 1'b1; end
                4'b0100: begin offset = 2'd2; legal = 1'b1; end
                4'b1000: begin offset = 2'd3; legal = 1'b1; end
                4'b0011: begin hsize = HSIZE_HALF; offset = 2'd0; legal = 1'b1; end
                4'b1100: begin hsize = HSIZE_HALF; offset = 2'd2; legal = 1'b1; end
                4'b1111: begin hsize = HSIZE_WORD; offset = 2'd0; legal = 1'b1; end
                default: ;
            endcase
        end else begin
            offset = rd_offset;
            case (rd_size)
                2'b00: legal = 1'b1;
                2'b01: begin hsize = HSIZE_HALF; legal = ~rd_offset[0]; end
                2'b10: begin hsize = HSIZE_WORD; legal = (rd_offset == 2'b00); end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ahb_dmem_master.sv
// Single-outstanding AHB-Lite master for core loads and stores: one
// registered address phase, one data phase, HREADY waits and ERROR handling.
module ahb_dmem_master
    import ahb_dmem_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [31:0] d_addr_in,
    input  logic [31:0] wr_data_in,
    input  logic [3:0]  wr_mask_in,
    input  logic        wr_req_in,
    input  logic        rd_req_in,
    input  logic [1:0]  rd_addr_lo_in,
    input  logic [1:0]  rd_size_in,
    output logic        ready_out,
    output logic [31:0] haddr_out,
    output logic [1:0]  htrans_out,
    output logic        hwrite_out,
    output logic [2:0]  hsize_out,
    output logic [2:0]  hburst_out,
    output logic [31:0] hwdata_out,
    input  logic        hready_in,
    input  logic        hresp_in,
    input  logic [31:0] hrdata_in,
    output logic [31:0] rd_data_out,
    output logic        rd_valid_out,
    output logic        wr_done_out,
    output logic        err_out
);

    state_t      state;
    logic [31:0] wdata_q;
    logic [2:0]  dec_hsize;
    logic [1:0]  dec_offset;
    logic        dec_legal;
    logic        req_legal;
    logic        unused_addr_lo;

    // Low address bits always come from the mask or the load offset.
    assign unused_addr_lo = ^d_addr_in[1:0];

    ahb_size_decode u_size_decode (
        .is_write  (wr_req_in),
        .mask      (wr_mask_in),
        .rd_size   (rd_size_in),
        .rd_offset (rd_addr_lo_in),
        .hsize     (dec_hsize),
        .offset    (dec_offset),
        .legal     (dec_legal)
    );

    assign req_legal  = dec_legal & ~(wr_req_in & rd_req_in);
    assign ready_out  = (state == ST_IDLE);
    assign hburst_out = 3'b000;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state        <= ST_IDLE;
            wdata_q      <= '0;
            haddr_out    <= '0;
            htrans_out   <= HTRANS_IDLE;
            hwrite_out   <= 1'b0;
            hsize_out    <= HSIZE_BYTE;
            hwdata_out   <= '0;
            rd_data_out  <= '0;
            rd_valid_out <= 1'b0;
            wr_done_out  <= 1'b0;
            err_out      <= 1'b0;
        end else begin
            rd_valid_out <= 1'b0;
            wr_done_out  <= 1'b0;
            err_out      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (wr_req_in || rd_req_in) begin
                        if (req_legal) begin
                            haddr_out  <= {d_addr_in[31:2], dec_offset};
                            hwrite_out <= wr_req_in;
                            hsize_out  <= dec_hsize;
                            htrans_out <= HTRANS_NONSEQ;
                            wdata_q    <= wr_data_in;
                            state      <= ST_ADDR;
                        end else begin
                            err_out <= 1'b1;
                        end
                    end
                end
                ST_ADDR: begin
                    if (hready_in) begin
                        htrans_out <= HTRANS_IDLE;
                        if (hwrite_out) hwdata_out <= wdata_q;
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    // hresp with hready low is the first ERROR cycle: keep waiting.
                    if (hready_in) begin
                        state <= ST_IDLE;
                        if (hresp_in) begin
                            err_out <= 1'b1;
                        end else if (hwrite_out) begin
                            wr_done_out <= 1'b1;
                        end else begin
                            rd_valid_out <= 1'b1;
                            rd_data_out  <= hrdata_in;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_dmem_master.sv
// Directed bench for ahb_dmem_master; completion pulses are checked by a
// scoreboard monitor against hand-computed kind, cycle and read data.
module tb_ahb_dmem_master;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic [31:0] d_addr_in;
    logic [31:0] wr_data_in;
    logic [3:0]  wr_mask_in;
    logic        wr_req_in;
    logic        rd_req_in;
    logic [1:0]  rd_addr_lo_in;
    logic [1:0]  rd_size_in;
    logic        ready_out;
    logic [31:0] haddr_out;
    logic [1:0]  htrans_out;
    logic        hwrite_out;
    logic [2:0]  hsize_out;
    logic [2:0]  hburst_out;
    logic [31:0] hwdata_out;
    logic        hready_in;
    logic        hresp_in;
    logic [31:0] hrdata_in;
    logic [31:0] rd_data_out;
    logic        rd_valid_out;
    logic        wr_done_out;
    logic        err_out;

    localparam int K_RD  = 0;
    localparam int K_WR  = 1;
    localparam int K_ERR = 2;

    typedef struct {
        int          kind;
        logic [31:0] data;
        int          at;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    ahb_dmem_master dut (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .d_addr_in     (d_addr_in),
        .wr_data_in    (wr_data_in),
        .wr_mask_in    (wr_mask_in),
        .wr_req_in     (wr_req_in),
        .rd_req_in     (rd_req_in),
        .rd_addr_lo_in (rd_addr_lo_in),
        .rd_size_in    (rd_size_in),
        .ready_out     (ready_out),
        .haddr_out     (haddr_out),
        .htrans_out    (htrans_out),
        .hwrite_out    (hwrite_out),
        .hsize_out     (hsize_out),
        .hburst_out    (hburst_out),
        .hwdata_out    (hwdata_out),
        .hready_in     (hready_in),
        .hresp_in      (hresp_in),
        .hrdata_in     (hrdata_in),
        .rd_data_out   (rd_data_out),
        .rd_valid_out  (rd_valid_out),
        .wr_done_out   (wr_done_out),
        .err_out       (err_out)
    );

    always #5 clk_in = ~clk_in;

    // cyc = number of rising edges so far; the cycle sampled at a negedge is cyc+1.
    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic tick();
        @(negedge clk_in);
    endtask

    task automatic expect_pulse(input int kind, input logic [31:0] data, input int at);
        exp_t e;
        e.kind = kind;
        e.data = data;
        e.at   = at;
        sbq.push_back(e);
    endtask

    // Scoreboard monitor: every completion/error pulse must match the queue head.
    always @(negedge clk_in) begin
        exp_t e;
        int   k;
        if (rst_n_in && (rd_valid_out || wr_done_out || err_out)) begin
            k = rd_valid_out ? K_RD : (wr_done_out ? K_WR : K_ERR);
            chk("pulse_onehot", 32'(rd_valid_out) + 32'(wr_done_out) + 32'(err_out), 32'd1);
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse actual kind=%0d cycle=%0d required none", k, cyc + 1);
            end else begin
                e = sbq.pop_front();
                chk("pulse_kind", 32'(k), 32'(e.kind));
                chk("pulse_cycle", 32'(cyc + 1), 32'(e.at));
                if (e.kind == K_RD) chk("rd_data", rd_data_out, e.data);
            end
        end
    end

    // hr/rs bit i drives hready/hresp for the i-th edge after acceptance.
    task automatic xfer(input string name, input bit wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] mask,
                        input logic [1:0] lo, input logic [1:0] size,
                        input logic [31:0] rdata, input logic [31:0] exp_haddr,
                        input logic [2:0] exp_hsize, input logic [15:0] hr,
                        input logic [15:0] rs, input int nsteps,
                        input int kind, input int done_ofs);
        int phase;
        d_addr_in     = addr;
        wr_data_in    = data;
        wr_mask_in    = mask;
        rd_addr_lo_in = lo;
        rd_size_in    = size;
        hrdata_in     = rdata;
        wr_req_in     = wr;
        rd_req_in     = !wr;
        expect_pulse(kind, rdata, cyc + 1 + done_ofs);
        tick();
        wr_req_in  = 1'b0;
        rd_req_in  = 1'b0;
        d_addr_in  = 32'hFFFF_FFFF;
        wr_data_in = 32'h0;
        wr_mask_in = 4'h0;
        phase = 0;
        for (int i = 0; i < nsteps; i++) begin
            hready_in = hr[i];
            hresp_in  = rs[i];
            if (phase == 0) begin
                chk({name, "_htrans_a"}, 32'(htrans_out), 32'h2);
                chk({name, "_haddr"}, haddr_out, exp_haddr);
                chk({name, "_hsize"}, 32'(hsize_out), 32'(exp_hsize));
                chk({name, "_hwrite"}, 32'(hwrite_out), 32'(wr));
                chk({name, "_ready_a"}, 32'(ready_out), 32'h0);
            end else if (phase == 1) begin
                chk({name, "_htrans_d"}, 32'(htrans_out), 32'h0);
                chk({name, "_ready_d"}, 32'(ready_out), 32'h0);
                if (wr) chk({name, "_hwdata"}, hwdata_out, data);
            end
            if (hr[i] && phase < 2) phase++;
            tick();
        end
        hready_in = 1'b1;
        hresp_in  = 1'b0;
        chk({name, "_ready_end"}, 32'(ready_out), 32'h1);
        chk({name, "_hburst"}, 32'(hburst_out), 32'h0);
    endtask

    task automatic illegal(input string name, input bit wr, input bit rd,
                           input logic [3:0] mask, input logic [1:0] lo,
                           input logic [1:0] size);
        d_addr_in     = 32'h0000_5000;
        wr_mask_in    = mask;
        rd_addr_lo_in = lo;
        rd_size_in    = size;
        wr_req_in     = wr;
        rd_req_in     = rd;
        expect_pulse(K_ERR, 32'h0, cyc + 2);
        tick();
        wr_req_in = 1'b0;
        rd_req_in = 1'b0;
        chk({name, "_htrans"}, 32'(htrans_out), 32'h0);
        chk({name, "_ready"}, 32'(ready_out), 32'h1);
        tick();
        chk({name, "_htrans2"}, 32'(htrans_out), 32'h0);
    endtask

    task automatic check_zero(input string name);
        chk({name, "_haddr"}, haddr_out, 32'h0);
        chk({name, "_ctrl"}, {21'h0, htrans_out, hwrite_out, hsize_out, hburst_out}, 32'h0);
        chk({name, "_hwdata"}, hwdata_out, 32'h0);
        chk({name, "_rd_data"}, rd_data_out, 32'h0);
        chk({name, "_pulses"}, {29'h0, rd_valid_out, wr_done_out, err_out}, 32'h0);
        chk({name, "_ready"}, 32'(ready_out), 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t1;
        rst_n_in      = 1'b0;
        d_addr_in     = 32'h0;
        wr_data_in    = 32'h0;
        wr_mask_in    = 4'h0;
        wr_req_in     = 1'b0;
        rd_req_in     = 1'b0;
        rd_addr_lo_in = 2'b00;
        rd_size_in    = 2'b00;
        hready_in     = 1'b1;
        hresp_in      = 1'b0;
        hrdata_in     = 32'h0;
        #2;
        check_zero("reset");
        tick();
        rst_n_in = 1'b1;
        tick();

        xfer("st_byte", 1'b1, 32'h0000_1000, 32'h00AB_0000, 4'b0100, 2'b00, 2'b00,
             32'h0, 32'h0000_1002, 3'b000, 16'b11, 16'b0, 2, K_WR, 3);
        xfer("ld_word_wait", 1'b0, 32'h0000_2000, 32'h0, 4'b0000, 2'b00, 2'b10,
             32'hDEAD_BEEF, 32'h0000_2000, 3'b010, 16'b100_0100, 16'b0, 7, K_RD, 8);
        xfer("ld_half", 1'b0, 32'h0000_3000, 32'h0, 4'b0000, 2'b10, 2'b01,
             32'h1234_5678, 32'h0000_3002, 3'b001, 16'b11, 16'b0, 2, K_RD, 3);
        xfer("st_half", 1'b1, 32'h0000_4004, 32'h9ABC_0000, 4'b1100, 2'b00, 2'b00,
             32'h0, 32'h0000_4006, 3'b001, 16'b11, 16'b0, 2, K_WR, 3);
        xfer("st_err", 1'b1, 32'h0000_6000, 32'hCAFE_F00D, 4'b1111, 2'b00, 2'b00,
             32'h0, 32'h0000_6000, 3'b010, 16'b101, 16'b110, 3, K_ERR, 4);
        chk("st_err_rd_data_held", rd_data_out, 32'h1234_5678);

        illegal("ill_mask", 1'b1, 1'b0, 4'b0110, 2'b00, 2'b00);
        illegal("ill_half_lo1", 1'b0, 1'b1, 4'b0000, 2'b01, 2'b01);
        illegal("ill_both", 1'b1, 1'b1, 4'b1111, 2'b00, 2'b10);

        // Back-to-back stores with wr_req held high across both.
        d_addr_in  = 32'h0000_7000;
        wr_data_in = 32'h0000_1234;
        wr_mask_in = 4'b0011;
        wr_req_in  = 1'b1;
        rd_req_in  = 1'b0;
        expect_pulse(K_WR, 32'h0, cyc + 4);
        expect_pulse(K_WR, 32'h0, cyc + 7);
        tick();
        t1 = cyc;
        chk("b2b_haddr1", haddr_out, 32'h0000_7000);
        d_addr_in  = 32'h0000_7004;
        wr_data_in = 32'h5600_0000;
        wr_mask_in = 4'b1000;
        for (int i = 0; i < 6; i++) begin
            logic [1:0] exp_tr;
            exp_tr = (i == 0 || i == 3) ? 2'b10 : 2'b00;
            chk("b2b_htrans", 32'(htrans_out), 32'(exp_tr));
            if (i == 2) chk("b2b_idle_gap", 32'(ready_out), 32'h1);
            if (i == 3) begin
                wr_req_in = 1'b0;
                chk("b2b_haddr2", haddr_out, 32'h0000_7007);
                chk("b2b_hsize2", 32'(hsize_out), 32'h0);
            end
            if (i == 4) chk("b2b_hwdata2", hwdata_out, 32'h5600_0000);
            tick();
        end
        chk("b2b_span", 32'(cyc - t1), 32'd6);

        // Reset while a load waits in its data phase.
        d_addr_in     = 32'h0000_8000;
        rd_addr_lo_in = 2'b00;
        rd_size_in    = 2'b10;
        rd_req_in     = 1'b1;
        tick();
        rd_req_in = 1'b0;
        tick();
        hready_in = 1'b0;
        tick();
        chk("rst_data_phase_ready", 32'(ready_out), 32'h0);
        chk("rst_data_phase_htrans", 32'(htrans_out), 32'h0);
        #2;
        rst_n_in = 1'b0;
        #1;
        check_zero("rst_in_data");
        tick();
        rst_n_in  = 1'b1;
        hready_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("post_rst_pulses", {29'h0, rd_valid_out, wr_done_out, err_out}, 32'h0);
            chk("post_rst_htrans", 32'(htrans_out), 32'h0);
        end

        for (int i = 0; i < 20 && sbq.size() != 0; i++) tick();
        chk("scoreboard_drained", 32'(sbq.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
